// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// one byte with odd parity on device clock falls, then check the device acknowledge.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_command,
    input  logic [7:0] command_to_send,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] REQ_LOAD     = 20'(REQ_CYCLES - 1);
    localparam logic [19:0] START_LOAD   = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] XFER_LOAD    = 20'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        WAIT_START,
        SEND,
        WAIT_ACK,
        WAIT_IDLE,
        RELEASE
    } state_t;

    // bit 0 = PS2_CLK, bit 1 = PS2_DAT; both idle high, so synchronisers reset to 1
    logic [1:0] pins_raw;
    logic [1:0] pins_sync;
    assign pins_raw = {ps2_dat_in, ps2_clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                meta_reg <= 1'b1;
                sync_reg <= 1'b1;
            end else begin
                meta_reg <= pins_raw[gi];
                sync_reg <= meta_reg;
            end
        end
        assign pins_sync[gi] = sync_reg;
    end

    logic clk_s;
    logic dat_s;
    logic fall;
    assign clk_s = pins_sync[0];
    assign dat_s = pins_sync[1];

    state_t      state_reg, state_next;
    logic [19:0] cnt_reg, cnt_next;
    logic [3:0]  n_reg, n_next;
    logic [7:0]  shift_reg, shift_next;
    logic        parity_reg, parity_next;
    logic        clk_prev_reg;
    logic        clk_oe_reg, clk_oe_next;
    logic        dat_oe_reg, dat_oe_next;
    logic        busy_reg;
    logic        sent_reg, sent_next;
    logic        err_reg, err_next;

    assign fall = clk_prev_reg & ~clk_s;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            n_reg        <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            clk_prev_reg <= 1'b1;
            clk_oe_reg   <= 1'b0;
            dat_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            sent_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            n_reg        <= n_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            clk_prev_reg <= clk_s;
            clk_oe_reg   <= clk_oe_next;
            dat_oe_reg   <= dat_oe_next;
            busy_reg     <= (state_next != IDLE);
            sent_reg     <= sent_next;
            err_reg      <= err_next;
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with state_reg.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        n_next      = n_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        clk_oe_next = 1'b0;
        dat_oe_next = 1'b0;
        sent_next   = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (send_command) begin
                    state_next  = INHIBIT;
                    cnt_next    = INHIBIT_LOAD;
                    n_next      = 4'd0;
                    shift_next  = command_to_send;
                    parity_next = ~^command_to_send;
                    clk_oe_next = 1'b1;
                end
            end

            INHIBIT: begin
                clk_oe_next = 1'b1;
                if (cnt_reg == 20'd0) begin
                    state_next  = REQUEST;
                    cnt_next    = REQ_LOAD;
                    dat_oe_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                end
            end

            REQUEST: begin
                clk_oe_next = 1'b1;
                dat_oe_next = 1'b1;
                if (cnt_reg == 20'd0) begin
                    state_next  = WAIT_START;
                    cnt_next    = START_LOAD;
                    clk_oe_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                end
            end

            WAIT_START: begin
                dat_oe_next = 1'b1;
                if (fall) begin
                    state_next  = SEND;
                    cnt_next    = XFER_LOAD;
                    n_next      = 4'd1;
                    dat_oe_next = ~shift_reg[0];
                    shift_next  = {1'b0, shift_reg[7:1]};
                end else if (cnt_reg == 20'd0) begin
                    state_next  = RELEASE;
                    dat_oe_next = 1'b0;
                    err_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                end
            end

            // The transfer timeout is not reloaded here; it spans SEND through WAIT_IDLE.
            SEND: begin
                dat_oe_next = dat_oe_reg;
                if (cnt_reg == 20'd0) begin
                    state_next  = RELEASE;
                    dat_oe_next = 1'b0;
                    err_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                    if (fall) begin
                        n_next = n_reg + 4'd1;
                        if (n_reg <= 4'd7) begin
                            dat_oe_next = ~shift_reg[0];
                            shift_next  = {1'b0, shift_reg[7:1]};
                        end else if (n_reg == 4'd8) begin
                            dat_oe_next = ~parity_reg;
                        end else if (n_reg == 4'd9) begin
                            dat_oe_next = 1'b0;
                        end else begin
                            dat_oe_next = 1'b0;
                            state_next  = WAIT_ACK;
                        end
                    end
                end
            end

            WAIT_ACK: begin
                if (cnt_reg == 20'd0) begin
                    state_next = RELEASE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                    if (fall) begin
                        if (!dat_s) begin
                            state_next = WAIT_IDLE;
                        end else begin
                            state_next = RELEASE;
                            err_next   = 1'b1;
                        end
                    end
                end
            end

            WAIT_IDLE: begin
                if (cnt_reg == 20'd0) begin
                    state_next = RELEASE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                    if (clk_s && dat_s) begin
                        state_next = IDLE;
                        sent_next  = 1'b1;
                    end
                end
            end

            RELEASE: begin
                state_next = IDLE;
                cnt_next   = 20'd0;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe                    = clk_oe_reg;
    assign ps2_dat_oe                    = dat_oe_reg;
    assign busy                          = busy_reg;
    assign command_was_sent              = sent_reg;
    assign error_communication_timed_out = err_reg;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Self-checking bench for ps2_command_tx: a PS/2 device model clocks the frame,
// a scoreboard holds expected frames and outcomes, vectors come from a table.
module tb_ps2_command_tx;

    logic       clk;
    logic       reset;
    logic       send_command;
    logic [7:0] command_to_send;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    logic dev_clk_low;
    logic dev_dat_low;
    bit   dev_silent;
    bit   dev_nack;
    bit   dev_abort;
    bit   dev_busy;
    int   dev_falls;
    int   pulse_count;

    int total;
    int bad;

    logic [10:0] exp_frame_q[$];
    int          exp_result_q[$];   // 1 = sent pulse, 2 = error pulse

    typedef struct {
        logic [7:0] cmd;
        logic       exp_par;
        bit         silent;
        bit         nack;
        bit         dup;
        bit         rst5;
        int         exp_out;   // 0 = no pulse (reset), 1 = sent, 2 = error
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    ps2_command_tx #(
        .INHIBIT_CYCLES(20),
        .REQ_CYCLES(5),
        .START_TIMEOUT(200),
        .XFER_TIMEOUT(2000)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .send_command(send_command),
        .command_to_send(command_to_send),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy(busy),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
    );

    // Open-drain wired-AND of host and device on both pins
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome monitor: pops the scoreboard on every pulse
    initial begin
        bit prev_pulse;
        int got;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && (command_was_sent || error_communication_timed_out)) begin
                pulse_count++;
                got = command_was_sent ? 1 : 2;
                check("pulse_exclusive", 32'(command_was_sent & error_communication_timed_out), 32'd0);
                check("pulse_width", 32'(prev_pulse), 32'd0);
                if (exp_result_q.size() == 0)
                    check("unexpected_pulse", 32'(got), 32'd0);
                else
                    check("outcome", 32'(got), 32'(exp_result_q.pop_front()));
                $display("pulse: %s", got == 1 ? "command_was_sent" : "error");
            end
            prev_pulse = command_was_sent | error_communication_timed_out;
        end
    end

    // Device model: 40-cycle half periods, samples data on rising clock edges
    initial begin
        logic [10:0] frame;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_busy    = 1'b0;
        forever begin
            @(negedge clk);
            if (!dev_silent && !dev_abort && !reset && busy && !ps2_clk_oe && ps2_dat_oe) begin
                dev_busy = 1'b1;
                frame    = '0;
                frame[0] = ps2_dat_in;
                for (int c = 0; c < 40 && !dev_abort; c++) @(negedge clk);
                for (int k = 1; k <= 12 && !dev_abort; k++) begin
                    dev_clk_low = 1'b1;
                    dev_falls++;
                    for (int c = 0; c < 40 && !dev_abort; c++) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) frame[k] = ps2_dat_in;
                    if (k == 10) dev_dat_low = !dev_nack;
                    for (int c = 0; c < 40 && !dev_abort; c++) @(negedge clk);
                end
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                if (!dev_abort) begin
                    if (exp_frame_q.size() == 0)
                        check("unexpected_frame", 32'(frame), 32'd0);
                    else
                        check("frame", 32'(frame), 32'(exp_frame_q.pop_front()));
                    $display("device received frame %03h", frame);
                end
                dev_busy = 1'b0;
            end
        end
    end

    task automatic run_vector(input int idx, input vec_t v);
        int n_inh;
        int n_req;
        int k;
        bit got;
        bit dup_done;
        bit aborted;
        got      = 1'b0;
        dup_done = 1'b0;
        aborted  = 1'b0;

        for (int c = 0; c < 2000 && (busy || dev_busy); c++) @(negedge clk);
        check("idle_before_send", 32'(busy | dev_busy), 32'd0);

        dev_silent  = v.silent;
        dev_nack    = v.nack;
        dev_falls   = 0;
        pulse_count = 0;
        if (!v.silent) exp_frame_q.push_back({1'b1, v.exp_par, v.cmd, 1'b0});
        if (v.exp_out != 0) exp_result_q.push_back(v.exp_out);

        command_to_send = v.cmd;
        send_command    = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);

        n_inh = 0;
        for (int c = 0; c < 100 && ps2_clk_oe && !ps2_dat_oe; c++) begin
            n_inh++;
            @(negedge clk);
        end
        n_req = 0;
        for (int c = 0; c < 100 && ps2_clk_oe && ps2_dat_oe; c++) begin
            n_req++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n_inh), 32'd20);
        check("request_len", 32'(n_req), 32'd5);
        check("start_bit_drive", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd1);

        if (v.silent) begin
            k = 0;
            for (int c = 0; c < 1000 && !error_communication_timed_out; c++) begin
                @(negedge clk);
                k++;
            end
            check("start_timeout", 32'(k), 32'd200);
            got = error_communication_timed_out;
        end else begin
            for (int c = 0; c < 6000; c++) begin
                @(negedge clk);
                send_command = 1'b0;
                if (v.dup && !dup_done && dev_falls == 3) begin
                    command_to_send = 8'h00;
                    send_command    = 1'b1;
                    dup_done        = 1'b1;
                end
                if (v.rst5 && dev_falls >= 5) begin
                    reset     = 1'b1;
                    dev_abort = 1'b1;
                    exp_frame_q.delete();
                    exp_result_q.delete();
                    @(negedge clk);
                    check("reset_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
                    check("reset_busy", 32'(busy), 32'd0);
                    check("reset_pulses", 32'({command_was_sent, error_communication_timed_out}), 32'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    for (int d = 0; d < 200 && dev_busy; d++) @(negedge clk);
                    dev_abort = 1'b0;
                    aborted   = 1'b1;
                    break;
                end
                if (command_was_sent || error_communication_timed_out) begin
                    got = 1'b1;
                    break;
                end
            end
        end

        if (aborted) begin
            repeat (50) @(negedge clk);
            check("no_pulse_after_reset", 32'(pulse_count), 32'd0);
            check("idle_after_reset", 32'(busy), 32'd0);
        end else begin
            check("pulse_seen", 32'(got), 32'd1);
            if (v.exp_out == 2 && got) begin
                @(negedge clk);
                check("oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
            end
            repeat (2) @(negedge clk);
            check("busy_cleared", 32'(busy), 32'd0);
            check("pulse_count", 32'(pulse_count), 32'd1);
            if (v.dup) begin
                repeat (100) @(negedge clk);
                check("dup_dropped", 32'(busy), 32'd0);
            end
        end
        $display("vector %0d: cmd=%02h silent=%0d nack=%0d dup=%0d rst=%0d expected_outcome=%0d pulses=%0d",
                 idx, v.cmd, v.silent, v.nack, v.dup, v.rst5, v.exp_out, pulse_count);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        send_command    = 1'b0;
        command_to_send = 8'h00;
        dev_silent      = 1'b0;
        dev_nack        = 1'b0;
        dev_abort       = 1'b0;
        dev_falls       = 0;
        pulse_count     = 0;

        //             cmd    par   sil nack dup rst out
        vecs[0] = '{8'hED, 1'b1, 0, 0, 0, 0, 1};
        vecs[1] = '{8'hF4, 1'b0, 0, 0, 0, 0, 1};
        vecs[2] = '{8'h3C, 1'b1, 1, 0, 0, 0, 2};
        vecs[3] = '{8'h5A, 1'b1, 0, 1, 0, 0, 2};
        vecs[4] = '{8'hF4, 1'b0, 0, 0, 0, 0, 1};
        vecs[5] = '{8'hED, 1'b1, 0, 0, 1, 0, 1};
        vecs[6] = '{8'hF4, 1'b0, 0, 0, 0, 1, 0};
        vecs[7] = '{8'hED, 1'b1, 0, 0, 0, 0, 1};
        vecs[8] = '{8'hFF, 1'b1, 0, 0, 0, 0, 1};
        vecs[9] = '{8'h80, 1'b0, 0, 0, 0, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", 32'(command_was_sent), 32'd0);
        check("rst_err", 32'(error_communication_timed_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vector(i, vecs[i]);

        for (int c = 0; c < 2000 && (busy || dev_busy); c++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_result_q.size() + exp_frame_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
